alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_arbiter_alu.sv | 23 ++
 rtl/alu_arbiter.sv | 167 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU arbiter and its ALU.
package alu_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    // True for every opcode the arbiter is able to execute.
    function automatic logic op_legal(input logic [2:0] op);
        case (op)
            3'b000, 3'b001, 3'b010, 3'b011, 3'b101: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU shared by both requesters: add, sub, and, or.
module alu_arbiter_alu
    import alu_pkg::*;
(
    input  logic [2:0]        op,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    output logic [WORD_W-1:0] y
);

    // Select the operation; add and sub wrap modulo 2^32.
    always_comb begin
        y = '0;
        case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a single shared ALU.
// One operation is in flight at a time: IDLE (accept) -> EXEC -> RESP.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int RR_EN = 1
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [WORD_W-1:0]   req0_a,
    input  logic [WORD_W-1:0]   req0_b,
    input  logic [2:0]          req0_op,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [WORD_W-1:0]   req1_a,
    input  logic [WORD_W-1:0]   req1_b,
    input  logic [2:0]          req1_op,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic [WORD_W-1:0]   rsp_result,
    output logic                rsp_zero,
    output logic                rsp_err,
    output logic                busy
);

    arb_state_e        state;
    arb_state_e        state_nxt;
    logic              last_grant;
    logic              grant_vld;
    logic              grant_id;
    logic              accept;

    logic [WORD_W-1:0] a_q;
    logic [WORD_W-1:0] b_q;
    logic [2:0]        op_q;
    logic              id_q;

    logic [2:0]        alu_op;
    logic [WORD_W-1:0] alu_y;
    logic              slt_n;
    logic              slt_v;
    logic [WORD_W-1:0] exec_result;
    logic              exec_zero;
    logic              exec_err;

    // Pick a winner: a lone requester always wins; on contention either
    // alternate against the last grant or favour requester 0.
    always_comb begin
        grant_vld = req0_valid | req1_valid;
        grant_id  = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = (RR_EN != 0) ? ~last_grant : 1'b0;
        end else begin
            grant_id = req1_valid;
        end
    end

    // Next state and ready outputs; ready is masked by rst_n so nothing
    // is offered while the block is held in reset.
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            IDLE: begin
                if (grant_vld && rst_n) begin
                    accept     = 1'b1;
                    req0_ready = ~grant_id;
                    req1_ready = grant_id;
                    state_nxt  = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register and last-grant pointer (pointer moves only on accept).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            state <= state_nxt;
            if (accept) begin
                last_grant <= grant_id;
            end
        end
    end

    // Capture the winner's operands once; they are never re-sampled.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q  <= grant_id ? req1_a  : req0_a;
            b_q  <= grant_id ? req1_b  : req0_b;
            op_q <= grant_id ? req1_op : req0_op;
            id_q <= grant_id;
        end
    end

    // Map the latched opcode onto the ALU: slt runs as a subtract, and
    // illegal codes just feed a harmless add whose output is dropped.
    always_comb begin
        alu_op = op_q;
        if (op_q == ALU_SLT) begin
            alu_op = ALU_SUB;
        end else if (!op_legal(op_q)) begin
            alu_op = ALU_ADD;
        end
    end

    alu_arbiter_alu u_alu (
        .op (alu_op),
        .a  (a_q),
        .b  (b_q),
        .y  (alu_y)
    );

    // Form the response word; signed less-than comes from the sign of the
    // difference corrected by the subtract overflow.
    always_comb begin
        slt_n       = alu_y[WORD_W-1];
        slt_v       = (a_q[WORD_W-1] != b_q[WORD_W-1]) &&
                      (alu_y[WORD_W-1] != a_q[WORD_W-1]);
        exec_err    = 1'b0;
        exec_result = alu_y;
        if (!op_legal(op_q)) begin
            exec_err    = 1'b1;
            exec_result = '0;
        end else if (op_q == ALU_SLT) begin
            exec_result = {{(WORD_W-1){1'b0}}, slt_n ^ slt_v};
        end
        exec_zero = !exec_err && (exec_result == '0);
    end

    // Response registers: loaded in EXEC, held through RESP until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
        end else if (state == EXEC) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= id_q;
            rsp_result <= exec_result;
            rsp_zero   <= exec_zero;
            rsp_err    <= exec_err;
        end else if ((state == RESP) && rsp_ready) begin
            rsp_valid  <= 1'b0;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a round-robin and a fixed-priority instance share
// one stimulus stream; each has its own grant model and response queue.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0;
    logic        req1_valid = 1'b0;
    logic        rsp_ready = 1'b0;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [2:0]  req0_op = '0, req1_op = '0;

    logic [1:0]  rdy0, rdy1, rv, rid, rz, rerr, bsy;
    logic [31:0] res_rr, res_fp;

    typedef struct packed {
        logic        id;
        logic [31:0] result;
        logic        zero;
        logic        err;
    } rsp_t;

    rsp_t sb_rr [$];
    rsp_t sb_fp [$];
    logic last_m [2];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.RR_EN(1)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(rdy0[0]), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(rdy1[0]), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(rv[0]), .rsp_ready(rsp_ready), .rsp_id(rid[0]), .rsp_result(res_rr),
        .rsp_zero(rz[0]), .rsp_err(rerr[0]), .busy(bsy[0])
    );

    alu_arbiter #(.RR_EN(0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(rdy0[1]), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(rdy1[1]), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(rv[1]), .rsp_ready(rsp_ready), .rsp_id(rid[1]), .rsp_result(res_fp),
        .rsp_zero(rz[1]), .rsp_err(rerr[1]), .busy(bsy[1])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of one operation, written from the opcode table.
    function automatic rsp_t model(input logic id, input logic [2:0] op,
                                   input logic [31:0] a, input logic [31:0] b);
        rsp_t r;
        r.id     = id;
        r.err    = 1'b0;
        r.result = '0;
        case (op)
            3'b000:  r.result = a + b;
            3'b001:  r.result = a - b;
            3'b010:  r.result = a & b;
            3'b011:  r.result = a | b;
            3'b101:  r.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: r.err    = 1'b1;
        endcase
        r.zero = !r.err && (r.result == 32'd0);
        return r;
    endfunction

    // Expected winner for instance d (0 = round-robin, 1 = fixed priority).
    function automatic logic grant_m(input int d, input logic v0, input logic v1);
        if (v0 && v1) begin
            return (d == 0) ? ~last_m[0] : 1'b0;
        end
        return v1 && !v0;
    endfunction

    function automatic rsp_t obs(input int d);
        rsp_t r;
        r.id     = rid[d];
        r.result = (d == 0) ? res_rr : res_fp;
        r.zero   = rz[d];
        r.err    = rerr[d];
        return r;
    endfunction

    // One full transaction starting in IDLE, just after a falling edge.
    task automatic do_op(input logic v0, input logic v1,
                         input logic [2:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                         input logic [2:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                         input int hold, input string tag);
        logic g [2];
        rsp_t exp [2];
        req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
        for (int d = 0; d < 2; d++) begin
            g[d]      = grant_m(d, v0, v1);
            last_m[d] = g[d];
            exp[d]    = g[d] ? model(1'b1, op1, a1, b1) : model(1'b0, op0, a0, b0);
            if (d == 0) sb_rr.push_back(exp[d]);
            else        sb_fp.push_back(exp[d]);
        end
        #1;
        for (int d = 0; d < 2; d++)
            chk({tag, " grant"}, 64'({rdy1[d], rdy0[d]}), g[d] ? 64'd2 : 64'd1);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = ~req0_a; req1_b = ~req1_b; req0_op = 3'b111; req1_op = 3'b110;
        #1;
        for (int d = 0; d < 2; d++)
            chk({tag, " exec ctrl"}, 64'({rv[d], bsy[d], rdy1[d], rdy0[d]}), 64'b0100);
        @(negedge clk);
        exp[0] = sb_rr.pop_front();
        exp[1] = sb_fp.pop_front();
        if (hold > 0) begin
            req0_valid = 1'b1; req1_valid = 1'b1;
        end
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) @(negedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                chk({tag, " resp ctrl"}, 64'({rv[d], bsy[d], rdy1[d], rdy0[d]}), 64'b1100);
                chk({tag, " resp data"}, 64'(obs(d)), 64'(exp[d]));
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        @(negedge clk);
        rsp_ready  = 1'b0;
        #1;
        for (int d = 0; d < 2; d++)
            chk({tag, " back idle"}, 64'({rv[d], bsy[d]}), 64'b00);
    endtask

    initial begin
        last_m[0] = 1'b1;
        last_m[1] = 1'b1;

        // Reset state, and no ready while in reset even with requests.
        #2;
        for (int d = 0; d < 2; d++)
            chk("reset outputs", 64'({rv[d], bsy[d], rid[d], rz[d], rerr[d]}), 64'd0);
        chk("reset result rr", 64'(res_rr), 64'd0);
        chk("reset result fp", 64'(res_fp), 64'd0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("reset ready", 64'({rdy1, rdy0}), 64'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(1'b1, 1'b0, 3'b000, 32'd5, 32'd7, 3'b000, 32'd0, 32'd0, 0, "add5+7");
        do_op(1'b0, 1'b1, 3'b000, 32'd0, 32'd0, 3'b101, 32'hFFFF_FFFF, 32'd1, 0, "slt-1<1");

        // Contention: round-robin alternates 0,1,0; fixed priority stays on 0.
        for (int i = 0; i < 3; i++)
            do_op(1'b1, 1'b1, 3'b010, 32'hF0F0_1234, 32'h0FF0_FFFF,
                  3'b011, 32'h0000_00F0, 32'h0000_000F, 0, "contend");

        do_op(1'b1, 1'b0, 3'b101, 32'h7FFF_FFFF, 32'h8000_0000, 3'b000, 32'd0, 32'd0, 0, "slt max>min");
        do_op(1'b0, 1'b1, 3'b000, 32'd0, 32'd0, 3'b001, 32'd9, 32'd9, 0, "sub9-9");
        do_op(1'b1, 1'b0, 3'b111, 32'd3, 32'd4, 3'b000, 32'd0, 32'd0, 0, "illegal111");
        do_op(1'b0, 1'b1, 3'b000, 32'd0, 32'd0, 3'b000, 32'hFFFF_FFFF, 32'd2, 5, "hold wrapadd");

        // Reset pulsed while an operation is in EXEC.
        req0_valid = 1'b1; req0_op = 3'b000; req0_a = 32'd3; req0_b = 32'd4;
        #1;
        chk("pre-reset grant rr", 64'({rdy1[0], rdy0[0]}), 64'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++)
            chk("midreset outputs", 64'({rv[d], bsy[d], rid[d], rz[d], rerr[d]}), 64'd0);
        chk("midreset result rr", 64'(res_rr), 64'd0);
        chk("midreset result fp", 64'(res_fp), 64'd0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("midreset ready", 64'({rdy1, rdy0}), 64'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        last_m[0] = 1'b1;
        last_m[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("post-reset quiet", 64'({rv, bsy}), 64'd0);
        end
        do_op(1'b1, 1'b1, 3'b000, 32'd10, 32'd20, 3'b001, 32'd1, 32'd2, 0, "after reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
